// File: rtl/fir_axil_mac_engine.sv
// AXI4-Lite FIR peripheral: one shared multiplier walks NUM_TAPS taps per accepted
// sample, then the accumulator is scaled/saturated into DOUT and OUT_VALID/irq raised.

module fir_axil_mac_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_TAPS           = 16,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int COEF_WIDTH         = 16,
    parameter int ACC_WIDTH          = 40,
    parameter int OUT_SHIFT          = 15
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    localparam int IDX_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PROD_W    = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int COEF_BASE = 16;

    localparam logic [31:0] REG_CTRL   = 32'd0;
    localparam logic [31:0] REG_STATUS = 32'd1;
    localparam logic [31:0] REG_DIN    = 32'd2;
    localparam logic [31:0] REG_DOUT   = 32'd3;
    localparam logic [31:0] REG_COUNT  = 32'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SCALE
    } state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               tap_q, tap_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_WIDTH-1:0] hist_q [NUM_TAPS];
    logic signed [SAMPLE_WIDTH-1:0] hist_d [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_d [NUM_TAPS];

    logic                    enable_q, enable_d;
    logic                    sat_en_q, sat_en_d;
    logic                    irq_en_q, irq_en_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    in_dropped_q, in_dropped_d;
    logic [SAMPLE_WIDTH-1:0] dout_q, dout_d;
    logic [31:0]             count_q, count_d;

    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic wr_en, rd_en, busy;
    logic [31:0] wr_word, rd_word;
    logic wr_coef_hit, rd_coef_hit;
    logic [IDX_W-1:0] wr_cidx, rd_cidx;

    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    scaled;
    logic [ACC_WIDTH-SAMPLE_WIDTH:0] scaled_top;
    logic                           scaled_fits;
    logic [SAMPLE_WIDTH-1:0]        sat_val;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT,
                         S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_WDATA};

    assign wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en = arready_q & S_AXI_ARVALID;
    assign busy  = (state_q != ST_IDLE);

    assign wr_word     = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign rd_word     = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign wr_coef_hit = (wr_word >= COEF_BASE) && (wr_word < COEF_BASE + NUM_TAPS);
    assign rd_coef_hit = (rd_word >= COEF_BASE) && (rd_word < COEF_BASE + NUM_TAPS);
    assign wr_cidx     = IDX_W'(wr_word - 32'(COEF_BASE));
    assign rd_cidx     = IDX_W'(rd_word - 32'(COEF_BASE));

    // Operands are widened first so the product is formed at full signed width.
    assign prod        = PROD_W'(hist_q[tap_q]) * PROD_W'(coef_q[tap_q]);
    assign scaled      = acc_q >>> OUT_SHIFT;
    assign scaled_top  = scaled[ACC_WIDTH-1:SAMPLE_WIDTH-1];
    assign scaled_fits = (&scaled_top) | ~(|scaled_top);
    assign sat_val     = {scaled[ACC_WIDTH-1], {(SAMPLE_WIDTH-1){~scaled[ACC_WIDTH-1]}}};

    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        hist_d       = hist_q;
        coef_d       = coef_q;
        enable_d     = enable_q;
        sat_en_d     = sat_en_q;
        irq_en_d     = irq_en_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        in_dropped_d = in_dropped_q;
        dout_d       = dout_q;
        count_d      = count_q;
        awready_d    = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        bvalid_d     = bvalid_q & ~S_AXI_BREADY;
        bresp_d      = bresp_q;
        arready_d    = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
        rvalid_d     = rvalid_q & ~S_AXI_RREADY;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;

        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_word)
                REG_CTRL: begin
                    enable_d = S_AXI_WDATA[0];
                    sat_en_d = S_AXI_WDATA[2];
                    irq_en_d = S_AXI_WDATA[3];
                    if (S_AXI_WDATA[1] && !busy) begin
                        hist_d = '{default: '0};
                    end
                end
                REG_STATUS: begin
                    if (S_AXI_WDATA[2]) overflow_d   = 1'b0;
                    if (S_AXI_WDATA[3]) in_dropped_d = 1'b0;
                end
                REG_DIN: begin
                    if (!busy && enable_q) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) begin
                            hist_d[k] = hist_q[k-1];
                        end
                        hist_d[0] = S_AXI_WDATA[SAMPLE_WIDTH-1:0];
                        count_d   = count_q + 32'd1;
                        acc_d     = '0;
                        tap_d     = '0;
                        state_d   = ST_MAC;
                    end else begin
                        in_dropped_d = 1'b1;
                    end
                end
                REG_DOUT, REG_COUNT: ;
                default: begin
                    if (wr_coef_hit && !busy) begin
                        coef_d[wr_cidx] = S_AXI_WDATA[COEF_WIDTH-1:0];
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            endcase
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (rd_word)
                REG_CTRL:   rdata_d = DW'({irq_en_q, sat_en_q, 1'b0, enable_q});
                REG_STATUS: rdata_d = DW'({in_dropped_q, overflow_q, out_valid_q, busy});
                REG_DIN:    rdata_d = '0;
                REG_DOUT: begin
                    rdata_d     = DW'($signed(dout_q));
                    out_valid_d = 1'b0;
                end
                REG_COUNT:  rdata_d = DW'(count_q);
                default: begin
                    if (rd_coef_hit) begin
                        rdata_d = DW'(coef_q[rd_cidx]);
                    end else begin
                        rresp_d = RESP_SLVERR;
                    end
                end
            endcase
        end

        // Evaluated after the bus side so a hardware set beats a same-cycle W1C/read clear.
        case (state_q)
            ST_MAC: begin
                acc_d = acc_q + ACC_WIDTH'(prod);
                tap_d = tap_q + IDX_W'(1);
                if (tap_q == IDX_W'(NUM_TAPS - 1)) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                if (scaled_fits) begin
                    dout_d = scaled[SAMPLE_WIDTH-1:0];
                end else begin
                    overflow_d = 1'b1;
                    dout_d     = sat_en_q ? sat_val : scaled[SAMPLE_WIDTH-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: ;
        endcase
    end

    // NOTE: history and coefficients live in flops that must read 0 after reset, so they are reset here.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            acc_q        <= '0;
            hist_q       <= '{default: '0};
            coef_q       <= '{default: '0};
            enable_q     <= 1'b0;
            sat_en_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            in_dropped_q <= 1'b0;
            dout_q       <= '0;
            count_q      <= '0;
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            hist_q       <= hist_d;
            coef_q       <= coef_d;
            enable_q     <= enable_d;
            sat_en_q     <= sat_en_d;
            irq_en_q     <= irq_en_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            in_dropped_q <= in_dropped_d;
            dout_q       <= dout_d;
            count_q      <= count_d;
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign irq           = out_valid_q & irq_en_q;

endmodule

// File: tb/tb_fir_axil_mac_engine.sv
// Directed bench for fir_axil_mac_engine: bus tasks queue the expected response,
// a negedge monitor pops and compares each B/R beat as the DUT presents it.

module tb_fir_axil_mac_engine;

    localparam int NUM_TAPS = 16;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [6:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [6:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        irq;

    always #5 ACLK = ~ACLK;

    fir_axil_mac_engine #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(7),
        .NUM_TAPS          (NUM_TAPS),
        .SAMPLE_WIDTH      (16),
        .COEF_WIDTH        (16),
        .ACC_WIDTH         (40),
        .OUT_SHIFT         (15)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .irq          (irq)
    );

    typedef struct {
        bit          is_read;
        logic [1:0]  resp;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(negedge ACLK) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_b: got BRESP %0d, expected no response", S_AXI_BRESP);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "/chan"}, 32'(0), 32'(mon_e.is_read));
                check({mon_e.name, "/bresp"}, 32'(S_AXI_BRESP), 32'(mon_e.resp));
            end
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_r: got RDATA 0x%08h, expected no response", S_AXI_RDATA);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "/chan"}, 32'(1), 32'(mon_e.is_read));
                check({mon_e.name, "/rresp"}, 32'(S_AXI_RRESP), 32'(mon_e.resp));
                check({mon_e.name, "/rdata"}, S_AXI_RDATA, mon_e.data);
            end
        end
    end

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input string name);
        exp_t e;
        bit   ok;
        e.is_read = 1'b0; e.resp = resp; e.data = '0; e.name = name;
        exp_q.push_back(e);
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; hs_cyc = cyc; break; end
        end
        if (!ok) timeout_fail({name, "/awready"});
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail({name, "/bvalid"});
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [6:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input string name);
        exp_t e;
        bit   ok;
        e.is_read = 1'b1; e.resp = resp; e.data = data; e.name = name;
        exp_q.push_back(e);
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail({name, "/arready"});
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail({name, "/rvalid"});
        @(posedge ACLK); #1;
    endtask

    // Waits for irq (IRQ_EN set) and checks it rose NUM_TAPS+2 cycles after the DIN handshake.
    task automatic wait_result(input string name, input int start_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (irq) begin
                seen = 1'b1;
                check({name, "/latency"}, 32'(cyc - start_cyc), 32'(NUM_TAPS + 2));
                break;
            end
        end
        if (!seen) timeout_fail({name, "/irq"});
    endtask

    task automatic read_dout(input logic [31:0] exp, input string name);
        axi_read(7'h0C, exp, OKAY, name);
        check({name, "/irq_low"}, 32'(irq), 32'(0));
    endtask

    logic [31:0] impulse_exp [6] = '{32'h80, 32'h100, 32'h180, 32'h200, 32'h280, 32'h300};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int din_hs;
        bit irq_seen;
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (4) @(negedge ACLK);
        check("rst/bus_idle", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                   S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}), 32'(0));
        check("rst/rdata", S_AXI_RDATA, 32'(0));
        check("rst/irq", 32'(irq), 32'(0));
        ARESETN = 1'b1;

        axi_read(7'h00, 32'h0, OKAY, "rst/ctrl");
        axi_read(7'h04, 32'h0, OKAY, "rst/status");
        axi_read(7'h08, 32'h0, OKAY, "rst/din");
        axi_read(7'h0C, 32'h0, OKAY, "rst/dout");
        axi_read(7'h10, 32'h0, OKAY, "rst/count");
        axi_read(7'h40, 32'h0, OKAY, "rst/coef0");
        axi_read(7'h7C, 32'h0, OKAY, "rst/coef15");
        axi_read(7'h20, 32'h0, SLVERR, "unmapped_rd");
        axi_write(7'h24, 32'hDEAD_BEEF, SLVERR, "unmapped_wr");

        // Impulse response: ENABLE | IRQ_EN, COEF[k] = 0x100*(k+1).
        axi_write(7'h00, 32'h9, OKAY, "imp/ctrl");
        for (int k = 0; k < NUM_TAPS; k++)
            axi_write(7'(7'h40 + 4 * k), 32'(32'h100 * (k + 1)), OKAY, $sformatf("imp/coef%0d", k));
        axi_read(7'h54, 32'h600, OKAY, "imp/coef5_rd");
        for (int i = 0; i < 6; i++) begin
            axi_write(7'h08, (i == 0) ? 32'h4000 : 32'h0, OKAY, $sformatf("imp/din%0d", i));
            wait_result($sformatf("imp/res%0d", i), hs_cyc);
            axi_read(7'h04, 32'h2, OKAY, $sformatf("imp/status%0d", i));
            read_dout(impulse_exp[i], $sformatf("imp/dout%0d", i));
        end
        axi_read(7'h10, 32'd6, OKAY, "imp/count");

        // Saturation with SAT_EN=1, history cleared first.
        axi_write(7'h00, 32'hF, OKAY, "sat/ctrl");
        for (int k = 0; k < NUM_TAPS; k++)
            axi_write(7'(7'h40 + 4 * k), 32'h7FFF, OKAY, $sformatf("sat/coef%0d", k));
        axi_write(7'h08, 32'h7FFF, OKAY, "sat/din0");
        wait_result("sat/res0", hs_cyc);
        read_dout(32'h7FFE, "sat/dout0");
        axi_write(7'h08, 32'h7FFF, OKAY, "sat/din1");
        wait_result("sat/res1", hs_cyc);
        axi_read(7'h04, 32'h6, OKAY, "sat/status");
        read_dout(32'h0000_7FFF, "sat/dout1");

        // Same stimulus with SAT_EN=0: low 16 bits of 0xFFFC, sign-extended.
        axi_write(7'h00, 32'hB, OKAY, "wrap/ctrl");
        axi_write(7'h08, 32'h7FFF, OKAY, "wrap/din0");
        wait_result("wrap/res0", hs_cyc);
        read_dout(32'h7FFE, "wrap/dout0");
        axi_write(7'h08, 32'h7FFF, OKAY, "wrap/din1");
        wait_result("wrap/res1", hs_cyc);
        read_dout(32'hFFFF_FFFC, "wrap/dout1");
        axi_read(7'h04, 32'h4, OKAY, "wrap/status");
        axi_write(7'h04, 32'h4, OKAY, "wrap/w1c");
        axi_read(7'h04, 32'h0, OKAY, "wrap/status_clr");
        axi_read(7'h10, 32'd10, OKAY, "wrap/count");

        // Drop while busy: 0x4000*0x7FFF >>> 15 = 0x3FFF.
        axi_write(7'h00, 32'hB, OKAY, "drop/ctrl");
        axi_write(7'h08, 32'h4000, OKAY, "drop/din0");
        din_hs = hs_cyc;
        axi_write(7'h08, 32'h1111, OKAY, "drop/din1");
        wait_result("drop/res", din_hs);
        axi_read(7'h04, 32'hA, OKAY, "drop/status");
        read_dout(32'h3FFF, "drop/dout");
        axi_read(7'h10, 32'd11, OKAY, "drop/count");
        axi_write(7'h04, 32'h8, OKAY, "drop/w1c");
        axi_read(7'h04, 32'h0, OKAY, "drop/status_clr");
        axi_write(7'h00, 32'h8, OKAY, "dis/ctrl");
        axi_write(7'h08, 32'h5, OKAY, "dis/din");
        axi_read(7'h04, 32'h8, OKAY, "dis/status");
        axi_read(7'h10, 32'd11, OKAY, "dis/count");
        axi_write(7'h04, 32'h8, OKAY, "dis/w1c");

        // Coefficient write while MAC runs; h = {0x10, 0x4000} -> 0x400F.
        axi_write(7'h00, 32'h9, OKAY, "busy/ctrl");
        axi_write(7'h08, 32'h10, OKAY, "busy/din");
        din_hs = hs_cyc;
        axi_write(7'h4C, 32'h1234, SLVERR, "busy/coef3_wr");
        axi_read(7'h4C, 32'h7FFF, OKAY, "busy/coef3_rd");
        axi_read(7'h0C, 32'h3FFF, OKAY, "busy/dout_prev");
        axi_read(7'h04, 32'h1, OKAY, "busy/status");
        wait_result("busy/res", din_hs);
        read_dout(32'h400F, "busy/dout");
        axi_write(7'h4C, 32'h1234, OKAY, "idle/coef3_wr");
        axi_read(7'h4C, 32'h0000_1234, OKAY, "idle/coef3_rd");
        axi_write(7'h50, 32'h1234_8000, OKAY, "idle/coef4_wr");
        axi_read(7'h50, 32'hFFFF_8000, OKAY, "idle/coef4_rd");
        axi_read(7'h10, 32'd12, OKAY, "busy/count");

        // Reset pulse in the middle of MAC aborts the computation.
        axi_write(7'h08, 32'h0100, OKAY, "rstmac/din");
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("rstmac/bus_idle", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                      S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}), 32'(0));
        check("rstmac/rdata", S_AXI_RDATA, 32'(0));
        ARESETN = 1'b1;
        irq_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            if (irq) irq_seen = 1'b1;
        end
        check("rstmac/irq", 32'(irq_seen), 32'(0));
        axi_read(7'h04, 32'h0, OKAY, "rstmac/status");
        axi_read(7'h00, 32'h0, OKAY, "rstmac/ctrl");
        axi_read(7'h40, 32'h0, OKAY, "rstmac/coef0");
        axi_read(7'h4C, 32'h0, OKAY, "rstmac/coef3");
        axi_read(7'h0C, 32'h0, OKAY, "rstmac/dout");
        axi_read(7'h10, 32'h0, OKAY, "rstmac/count");

        repeat (5) @(negedge ACLK);
        check("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
